// File: rtl/line_fill_server.sv
// ----------------------------------------------------------------------------
// line_fill_server
//
// Memory-side responder for cache line traffic. Accepts one line read
// (refill) or line write (eviction) at a time over a valid/ready handshake,
// serves it from an internal line-wide backing array after a fixed latency,
// and returns a full-line response. One request outstanding, strictly in
// order.
//
// Optional feature macro: REQ_COUNT_EN
//   defined   -> rd_count/wr_count ports and saturating request counters exist
//   undefined -> ports and counter logic are absent
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   req_valid  in   request present
//   req_ready  out  responder can accept a request (IDLE only)
//   req_write  in   1 = line write, 0 = line read
//   req_addr   in   byte address; low log2(LINE_SIZE) bits ignored
//   req_wdata  in   write line data
//   rsp_valid  out  response present
//   rsp_ready  in   requester accepts response
//   rsp_data   out  read line data; 0 for writes and errors
//   rsp_err    out  address out of range
//   rd_count   out  accepted reads, saturating   (REQ_COUNT_EN only)
//   wr_count   out  accepted writes, saturating  (REQ_COUNT_EN only)
// ----------------------------------------------------------------------------
module line_fill_server #(
    parameter int LINE_SIZE    = 16,
    parameter int MEM_ADDR_W   = 32,
    parameter int MEM_LINES    = 256,
    parameter int READ_LATENCY = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [MEM_ADDR_W-1:0]  req_addr,
    input  logic [LINE_SIZE*8-1:0] req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [LINE_SIZE*8-1:0] rsp_data,
    output logic                   rsp_err
`ifdef REQ_COUNT_EN
    ,
    output logic [15:0]            rd_count,
    output logic [15:0]            wr_count
`endif
);

    localparam int DATA_W = LINE_SIZE * 8;
    localparam int OFS    = $clog2(LINE_SIZE);
    localparam int IDX_W  = $clog2(MEM_LINES);
    localparam int LAT_W  = 8;

    // Any address bit at or above OFS+IDX_W flags the request as out of range.
    localparam logic [MEM_ADDR_W-1:0] HI_MASK =
        ~MEM_ADDR_W'((64'd1 << (OFS + IDX_W)) - 64'd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LAT_W-1:0]   lat_q;
    logic               write_q;
    logic               err_q;
    logic [IDX_W-1:0]   idx_q;
    logic [DATA_W-1:0]  rsp_data_q;
    logic               rsp_err_q;

    logic [DATA_W-1:0]  mem [MEM_LINES];

    logic [IDX_W-1:0]   req_idx;
    logic               req_oor;
    logic               accept;
    logic               fire;
    logic               done;

    assign req_idx = req_addr[OFS +: IDX_W];
    assign req_oor = |(req_addr & HI_MASK);

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        fire      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (lat_q == '0) begin
                    fire    = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, request latch, latency counter and response registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            lat_q      <= '0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q <= req_write;
                err_q   <= req_oor;
                idx_q   <= req_idx;
                lat_q   <= LAT_W'(READ_LATENCY - 1);
            end else if (state_q == WAIT && lat_q != '0) begin
                lat_q <= lat_q - 1'b1;
            end
            // The array is read only here, on the last WAIT cycle, so a write
            // accepted earlier is always visible.
            if (fire) begin
                rsp_data_q <= (!write_q && !err_q) ? mem[idx_q] : '0;
                rsp_err_q  <= err_q;
            end else if (done) begin
                rsp_err_q <= 1'b0;
            end
        end
    end

    // Backing array: not reset; writes land on the accept edge. Gating with
    // reset keeps a request presented during reset from touching the array.
    always_ff @(posedge clock) begin
        if (accept && !reset && req_write && !req_oor)
            mem[req_idx] <= req_wdata;
    end

    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

`ifdef REQ_COUNT_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    // Saturating counters; out-of-range requests count too.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (accept) begin
            if (!req_write && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            if (req_write && wr_cnt_q != 16'hFFFF)  wr_cnt_q <= wr_cnt_q + 16'd1;
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_line_fill_server.sv
// ----------------------------------------------------------------------------
// tb_line_fill_server
//
// Directed bench for line_fill_server with default parameters
// (16-byte lines, 256 lines, latency 4). Inputs are driven on the falling
// edge and outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_line_fill_server;

    logic         clock;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [31:0]  req_addr;
    logic [127:0] req_wdata;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_data;
    logic         rsp_err;
`ifdef REQ_COUNT_EN
    logic [15:0]  rd_count;
    logic [15:0]  wr_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [127:0] PAT_A5 = {16{8'hA5}};
    localparam logic [127:0] PAT_5A = {16{8'h5A}};
    localparam logic [127:0] PAT_L0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    line_fill_server dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
`ifdef REQ_COUNT_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request and return just after the accepting edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [127:0] d);
        int n;
        @(negedge clock);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) check("accept_timeout", 1'b0, 1'b1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    // Count edges after the accept edge until rsp_valid is seen.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (lat < 50) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (rsp_valid) break;
        end
        if (!rsp_valid) check("rsp_timeout", 1'b0, 1'b1);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic transact(input logic w, input logic [31:0] a, input logic [127:0] d,
                            output logic [127:0] rd, output logic re, output int lat);
        issue(w, a, d);
        wait_rsp(lat);
        rd = rsp_data;
        re = rsp_err;
        finish_rsp();
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    logic [127:0] d;
    logic         e;
    int           lat;
    logic         seen;

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // 1: reset state on the first cycle after release
        @(negedge clock);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_err",   rsp_err,   1'b0);
        check("rst_rsp_data",  rsp_data,  128'h0);

        // 2: write line 0x40, read back through 0x4C (offset bits ignored)
        transact(1'b1, 32'h40, PAT_A5, d, e, lat);
        check("wr40_data", d, 128'h0);
        check("wr40_err",  e, 1'b0);
        check("wr40_lat",  lat, 4);
        transact(1'b0, 32'h4C, '0, d, e, lat);
        check("rd4c_data", d, PAT_A5);
        check("rd4c_err",  e, 1'b0);
        check("rd4c_lat",  lat, 4);
        @(negedge clock);
        check("rd4c_idle", req_ready, 1'b1);

        // 3: response held under backpressure
        issue(1'b0, 32'h40, '0);
        wait_rsp(lat);
        check("hold_lat", lat, 4);
        for (int i = 0; i < 6; i++) begin
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_data",  rsp_data,  PAT_A5);
            check("hold_ready", req_ready, 1'b0);
            @(negedge clock);
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
        @(negedge clock);
        check("hold_rel_ready", req_ready, 1'b1);
        check("hold_rel_valid", rsp_valid, 1'b0);
        check("hold_rel_data",  rsp_data,  PAT_A5);

        // 4: out-of-range 0x1000 aliases line 0 in the index bits only
        transact(1'b1, 32'h0, PAT_L0, d, e, lat);
        check("wr0_err", e, 1'b0);
        transact(1'b1, 32'h1000, PAT_5A, d, e, lat);
        check("oor_wr_err",  e, 1'b1);
        check("oor_wr_data", d, 128'h0);
        @(negedge clock);
        check("oor_err_clr", rsp_err, 1'b0);
        transact(1'b0, 32'h1000, '0, d, e, lat);
        check("oor_rd_err",  e, 1'b1);
        check("oor_rd_data", d, 128'h0);
        check("oor_rd_lat",  lat, 4);
        transact(1'b0, 32'h0, '0, d, e, lat);
        check("line0_kept", d, PAT_L0);
        check("line0_err",  e, 1'b0);

        // 5: reset two cycles after a read accept aborts it
        issue(1'b0, 32'h40, '0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (rsp_valid) seen = 1'b1;
        end
        check("abort_no_rsp",  seen, 1'b0);
        check("abort_ready",   req_ready, 1'b1);
        check("abort_data",    rsp_data, 128'h0);
        transact(1'b0, 32'h40, '0, d, e, lat);
        check("after_abort_data", d, PAT_A5);
        check("after_abort_lat",  lat, 4);

`ifdef REQ_COUNT_EN
        // 6: request counters, including saturation
        pulse_reset();
        check("cnt_rst_rd", rd_count, 16'd0);
        check("cnt_rst_wr", wr_count, 16'd0);
        for (int i = 0; i < 3; i++) transact(1'b0, 32'h40, '0, d, e, lat);
        for (int i = 0; i < 2; i++) transact(1'b1, 32'h80, PAT_5A, d, e, lat);
        @(negedge clock);
        check("cnt_rd3", rd_count, 16'd3);
        check("cnt_wr2", wr_count, 16'd2);
        force dut.rd_cnt_q = 16'hFFFE;
        @(negedge clock);
        release dut.rd_cnt_q;
        for (int i = 0; i < 3; i++) transact(1'b0, 32'h1000, '0, d, e, lat);
        @(negedge clock);
        check("cnt_rd_sat", rd_count, 16'hFFFF);
        check("cnt_wr_hold", wr_count, 16'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
